// File: rtl/csa_seq_pkg.sv
// Shared definitions for the sliced carry-select add sequencer: FSM states,
// slice width and the slice-index width helper.
package csa_seq_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice counter width: ceil(log2(n)), never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/CSA_2.sv
// Two-bit carry-select adder slice: both carry hypotheses are formed up front
// and cin picks one; second_out carries the unselected {carry, sum} candidate.
module CSA_2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout,
    output logic [2:0] second_out
);

    logic [2:0] res_c0;
    logic [2:0] res_c1;

    assign res_c0 = {1'b0, a} + {1'b0, b};
    assign res_c1 = res_c0 + 3'd1;

    assign {cout, sum} = cin ? res_c1 : res_c0;
    assign second_out  = cin ? res_c0 : res_c1;

endmodule

// File: rtl/csa_slice_sequencer.sv
// Wide adder built from one 2-bit carry-select slice, stepped LSB to MSB with
// a start/done handshake. Define CSA_SEQ_OVERFLOW_EN to build signed overflow.
module csa_slice_sequencer
    import csa_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = idx_width(N);

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx;

    logic [SLICE_W-1:0] a_sl [N];
    logic [SLICE_W-1:0] b_sl [N];
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               accept;
    logic               last;

    // Split latched operands into per-slice lanes so the mux is a plain array pick.
    for (genvar gi = 0; gi < N; gi++) begin : g_slice_lane
        assign a_sl[gi] = a_q[gi*SLICE_W +: SLICE_W];
        assign b_sl[gi] = b_q[gi*SLICE_W +: SLICE_W];
    end

    assign slice_a = a_sl[idx];
    assign slice_b = b_sl[idx];

    CSA_2 u_slice (
        .a          (slice_a),
        .b          (slice_b),
        .cin        (carry_q),
        .cout       (slice_cout),
        .sum        (slice_sum),
        .second_out ()
    );

    // A new request is taken in IDLE and also straight out of DONE.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (idx == IDX_W'(N - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state   <= RUN;
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum[idx*SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    idx     <= idx + 1'b1;
                    if (last) begin
                        state <= DONE;
                        cout  <= slice_cout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSA_SEQ_OVERFLOW_EN
    logic overflow_reg;

    // The MSB of the result is still in flight on the final slice, so take it from the adder.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (accept) begin
            overflow_reg <= 1'b0;
        end else if ((state == RUN) && last) begin
            overflow_reg <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
        end
    end

    assign overflow = overflow_reg;
`else
    assign overflow = 1'b0;
`endif

endmodule
